// File: rtl/icache_refill_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
// The cache itself imports the same geometry.
package icache_refill_pkg;

  localparam int unsigned ADDR_WIDTH  = 17;
  localparam int unsigned BLOCK_WIDTH = 4;
  localparam int unsigned BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
  localparam int unsigned CNT_WIDTH   = BLOCK_WIDTH + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDone  = 2'd2
  } refillState_e;

endpackage

// File: rtl/icache_refill.sv
// Miss-refill engine: fetches one cache block a byte at a time over the arbitrated
// RAM read port and hands the assembled block to the cache for a single cycle.
module icache_refill
  import icache_refill_pkg::*;
(
  input  logic                              clkIn,
  input  logic                              resetIn,
  input  logic                              reqValidIn,
  input  logic                              missIn,
  input  logic [ADDR_WIDTH-1:0]             missAddrIn,
  input  logic                              flushIn,
  input  logic                              memGrantIn,
  input  logic [7:0]                        ramDataIn,
  output logic                              ramReqOut,
  output logic [ADDR_WIDTH-1:0]             ramAddrOut,
  output logic                              busyOut,
  output logic                              blockValidOut,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] blockAddrOut,
  output logic [BLOCK_SIZE*8-1:0]           blockDataOut
);

  refillState_e                      state;
  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] blockAddr;
  logic [CNT_WIDTH-1:0]              issueCnt;
  logic [CNT_WIDTH-1:0]              recvCnt;
  logic                              pending;
  logic [BLOCK_SIZE*8-1:0]           dataBuf;
  logic [BLOCK_SIZE*8-1:0]           assembled;
  logic                              start;
  logic                              accepted;
  logic                              lastByte;
  logic                              unusedOffset;

  assign start      = reqValidIn && missIn && !flushIn;
  assign ramReqOut  = (state == StFetch) && (issueCnt < CNT_WIDTH'(BLOCK_SIZE));
  // Offset comes only from the low counter bits, so addresses never carry out of the block.
  assign ramAddrOut = {blockAddr, issueCnt[BLOCK_WIDTH-1:0]};
  assign accepted   = ramReqOut && memGrantIn;
  assign busyOut    = (state != StIdle);
  assign lastByte   = pending && (recvCnt == CNT_WIDTH'(BLOCK_SIZE - 1));

  assign unusedOffset = ^missAddrIn[BLOCK_WIDTH-1:0];

  always_comb begin
    assembled = dataBuf;
    assembled[{recvCnt[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state         <= StIdle;
      blockAddr     <= '0;
      issueCnt      <= '0;
      recvCnt       <= '0;
      pending       <= 1'b0;
      dataBuf       <= '0;
      blockValidOut <= 1'b0;
      blockAddrOut  <= '0;
      blockDataOut  <= '0;
    end else begin
      blockValidOut <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            blockAddr <= missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
            issueCnt  <= '0;
            recvCnt   <= '0;
            pending   <= 1'b0;
            state     <= StFetch;
          end
        end
        StFetch: begin
          if (flushIn) begin
            // Partial data stays in dataBuf; the visible block is untouched.
            issueCnt <= '0;
            recvCnt  <= '0;
            pending  <= 1'b0;
            state    <= StIdle;
          end else begin
            pending <= accepted;
            if (accepted) begin
              issueCnt <= issueCnt + 1'b1;
            end
            if (pending) begin
              dataBuf <= assembled;
              recvCnt <= recvCnt + 1'b1;
              if (lastByte) begin
                state         <= StDone;
                blockValidOut <= 1'b1;
                blockAddrOut  <= blockAddr;
                blockDataOut  <= assembled;
              end
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Miss-refill engine between the instruction cache and the byte-wide unified RAM port. On a qualified cache miss it latches the block address and reads BLOCK_SIZE consecutive bytes through an arbitrated, pipelined RAM read port. It assembles them little-endian into one block, then presents the block to the cache fill port (valid, block address, data) for exactly one cycle.

Parameters:
ADDR_WIDTH, 17, byte-address width of instruction space
BLOCK_WIDTH, 4, log2 of cache block size in bytes
BLOCK_SIZE, 2**BLOCK_WIDTH, block size in bytes (16)

Ports:
clkIn  in  1  system clock
resetIn  in  1  asynchronous active-high reset
reqValidIn  in  1  fetch unit is requesting an instruction this cycle
missIn  in  1  cache miss indication; meaningful only when reqValidIn=1
missAddrIn  in  ADDR_WIDTH  instruction byte address of the request
flushIn  in  1  pipeline flush; aborts refill in progress
memGrantIn  in  1  arbiter grants RAM port this cycle
ramDataIn  in  8  RAM read byte, valid one cycle after an accepted request
ramReqOut  out  1  read request to arbiter/RAM
ramAddrOut  out  ADDR_WIDTH  byte address of read request
busyOut  out  1  refill in progress (state != IDLE)
blockValidOut  out  1  one-cycle fill strobe to cache
blockAddrOut  out  ADDR_WIDTH-BLOCK_WIDTH  block address of the filled block
blockDataOut  out  BLOCK_SIZE*8  block data; byte i at bits [8i+7:8i]

Behaviour:
- Reset: clock clkIn; reset resetIn, asynchronous and active-high. Reset forces state IDLE, issue/receive counters 0, pending flag 0, blockValidOut 0, blockAddrOut 0, blockDataOut 0. ramReqOut and busyOut are 0 in IDLE.
- Start condition: start = reqValidIn && missIn && !flushIn.
- States: IDLE, FETCH, DONE.
- IDLE:
  - On start, latch blockAddr = missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH].
  - Clear issueCnt, recvCnt and pending.
  - Next state FETCH.
- FETCH, issue side:
  - ramReqOut = (issueCnt < BLOCK_SIZE).
  - ramAddrOut = {blockAddr, issueCnt[BLOCK_WIDTH-1:0]}.
  - accepted = ramReqOut && memGrantIn; on accepted, issueCnt increments.
  - pending <= accepted.
- FETCH, receive side: when pending=1, capture ramDataIn into data byte recvCnt and increment recvCnt. Capturing byte BLOCK_SIZE-1 moves the state to DONE.
- DONE:
  - blockValidOut=1 for this single cycle (registered).
  - blockAddrOut and blockDataOut are stable during DONE and held afterwards until the next capture.
  - Next state IDLE; a new start is accepted only from IDLE.
- Latency with continuous grant:
  - start at cycle 0.
  - Requests at cycles 1..16, bytes captured at cycles 2..17.
  - blockValidOut high in cycle 18.
  - Earliest next start in cycle 19.
- Grant low: no issue, issueCnt holds, ramAddrOut holds. An already-pending byte is still captured. Non-contiguous grants are legal.
- Counters are BLOCK_WIDTH+1 bits wide. Address offset wraps only within the block; there is no carry into blockAddr.
- Flush:
  - In FETCH: next state IDLE, counters and pending cleared. Any in-flight byte is ignored, blockValidOut is never raised, and blockDataOut is not updated to partial data. Partial bytes go to an internal buffer; blockDataOut is loaded on the transition to DONE.
  - In DONE: no effect; the fill completes.
  - In IDLE: suppresses start.
- Reset mid-refill: immediate return to IDLE with all of the reset values above. Any RAM byte arriving afterwards is ignored.
- While busyOut=1, missIn and missAddrIn are ignored; a new miss is serviced after return to IDLE.

Decomposition:
- Shared package: ADDR_WIDTH, BLOCK_WIDTH and BLOCK_SIZE constants; state encoding (IDLE=2'd0, FETCH=2'd1, DONE=2'd2). The cache uses the same constants.
- No sub-module is warranted; the block is a single FSM with a byte-assembly buffer.

Test Plan:
- Basic refill: reset, then reqValidIn=1, missIn=1, missAddrIn=0x01234, grant always 1, RAM returns byte=addr[7:0] -> requests 0x01230..0x0123F in cycles 1..16; blockValidOut=1 only in cycle 18; blockAddrOut=0x0123; blockDataOut=0x3F3E3D3C3B3A39383736353433323130.
- Grant stalls: same miss with memGrantIn low on cycles 3,4 and 10 -> ramAddrOut held during stalls; no duplicate or skipped address; blockValidOut in cycle 21; data identical to the basic case.
- Flush mid-refill: flushIn=1 in cycle 8 -> state IDLE in cycle 9; blockValidOut never asserted; blockDataOut unchanged from prior value; a new miss at 0x00040 then fills block 0x0004 correctly.
- Async reset mid-refill: assert resetIn between clock edges in cycle 6 -> ramReqOut, busyOut and blockValidOut drop to 0 immediately, without waiting for a clock edge; blockDataOut=0; the stray byte next cycle is ignored.
- Unqualified miss: missIn=1, reqValidIn=0 for 10 cycles -> ramReqOut stays 0 and busyOut stays 0.
- Back-to-back misses: second miss (0x1FFF0) held high during the first refill -> ignored until IDLE; starts in cycle 19; addresses 0x1FFF0..0x1FFFF with no wrap into 0x00000; blockAddrOut=0x1FFF.
